// File: rtl/rd_pkt_framer.sv
// Frames raw read-data beats into one AXI-Stream packet per read command.
// A packet starts only once the downstream FIFO reports room for all of it.
module rd_pkt_framer #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [15:0]             cmd_id,
    input  logic [3:0]              cmd_user,
    input  logic [LEN_WIDTH-1:0]    cmd_len,
    input  logic                    d_valid,
    output logic                    d_ready,
    input  logic [DATA_WIDTH-1:0]   d_data,
    input  logic                    fifo_ready,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic [15:0]             m_axis_tid,
    output logic [3:0]              m_axis_tuser,
    output logic                    busy,
    output logic [31:0]             pkt_cnt
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_ROOM = 2'd1,
        S_STREAM    = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [LEN_WIDTH-1:0]    r_len;
    logic [LEN_WIDTH-1:0]    r_beat_cnt;
    logic [15:0]             r_cmd_id;
    logic [3:0]              r_cmd_user;

    logic                    r_tvalid;
    logic                    r_tlast;
    logic [DATA_WIDTH-1:0]   r_tdata;
    logic [15:0]             r_tid;
    logic [3:0]              r_tuser;
    logic [31:0]             r_pkt_cnt;

    logic                    w_cmd_ready;
    logic                    w_d_ready;
    logic                    w_cmd_fire;
    logic                    w_load;
    logic                    w_last_beat;
    logic                    w_tx_last;

    assign w_cmd_fire  = cmd_valid & w_cmd_ready;
    assign w_load      = d_valid & w_d_ready;
    assign w_last_beat = (r_beat_cnt == r_len);
    assign w_tx_last   = r_tvalid & m_axis_tready & r_tlast;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_state_nxt = S_WAIT_ROOM;
                end
            end
            S_WAIT_ROOM: begin
                if (fifo_ready) begin
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_load && w_last_beat) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_cmd_ready = 1'b0;
        w_d_ready   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_cmd_ready = 1'b1;
            end
            S_WAIT_ROOM: begin
                w_d_ready = 1'b0;
            end
            S_STREAM: begin
                // Accept a beat whenever the output register is free or draining.
                w_d_ready = ~r_tvalid | m_axis_tready;
            end
            default: begin
                w_cmd_ready = 1'b0;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_len      <= '0;
            r_beat_cnt <= '0;
            r_cmd_id   <= '0;
            r_cmd_user <= '0;
        end else if (w_cmd_fire) begin
            r_len      <= cmd_len;
            r_beat_cnt <= '0;
            r_cmd_id   <= cmd_id;
            r_cmd_user <= cmd_user;
        end else if (w_load && !w_last_beat) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
        end
    end

    // tid/tuser are copied per beat so a newly latched command cannot
    // disturb a final beat still waiting in the output register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_tdata  <= '0;
            r_tid    <= '0;
            r_tuser  <= '0;
        end else if (w_load) begin
            r_tvalid <= 1'b1;
            r_tlast  <= w_last_beat;
            r_tdata  <= d_data;
            r_tid    <= r_cmd_id;
            r_tuser  <= r_cmd_user;
        end else if (m_axis_tready) begin
            r_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_pkt_cnt <= '0;
        end else if (w_tx_last) begin
            r_pkt_cnt <= r_pkt_cnt + 32'd1;
        end
    end

    assign cmd_ready     = w_cmd_ready;
    assign d_ready       = w_d_ready;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tkeep  = '1;
    assign m_axis_tlast  = r_tlast;
    assign m_axis_tid    = r_tid;
    assign m_axis_tuser  = r_tuser;
    assign busy          = (r_state != S_IDLE) | r_tvalid;
    assign pkt_cnt       = r_pkt_cnt;

endmodule

// File: doc/rd_pkt_framer.md
Name: rd_pkt_framer

Overview:
Upstream neighbour of the read-data async FIFO wrapper, in the same clock domain as that FIFO's write side.
- Accepts a read command (id, user tag, beat count) and frames the raw read-data beats that follow into one AXI-Stream packet.
- Attaches tid/tuser to every beat and asserts tlast on the final beat.
- Starts a packet only when the FIFO reports room (its prog_full-derived ready), so a started packet never stalls on FIFO fullness.

Parameters:
DATA_WIDTH, 32, width of read data and m_axis_tdata
LEN_WIDTH, 16, width of cmd_len (beats minus one)

Ports:
aclk  in  1  clock
areset  in  1  synchronous reset, active-high
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_id  in  16  packet id, driven on m_axis_tid
cmd_user  in  4  packet tag, driven on m_axis_tuser
cmd_len  in  LEN_WIDTH  packet length in beats minus one
d_valid  in  1  raw read-data beat valid
d_ready  out  1  raw read-data beat accepted
d_data  in  DATA_WIDTH  raw read data
fifo_ready  in  1  downstream FIFO has room for a full packet (inverse of prog_full)
m_axis_tvalid  out  1  stream valid
m_axis_tready  in  1  stream ready (FIFO write-side tready)
m_axis_tdata  out  DATA_WIDTH  stream data
m_axis_tkeep  out  DATA_WIDTH/8  all ones
m_axis_tlast  out  1  final beat of packet
m_axis_tid  out  16  latched cmd_id
m_axis_tuser  out  4  latched cmd_user
busy  out  1  state != IDLE or m_axis_tvalid
pkt_cnt  out  32  packets completed (tlast handshakes), wraps at 2^32

Behaviour:
- Reset values, applied synchronously at aclk edge while areset=1:
  - state=IDLE; m_axis_tvalid=0, tlast=0, tdata/tid/tuser=0; pkt_cnt=0; beat_cnt=0.
  - A packet in flight is abandoned with no tlast. The remaining source beats are the system's problem.
- FSM states:
  - IDLE: cmd_ready=1, d_ready=0. On cmd_valid, latch id/user/len, clear beat_cnt, go to WAIT_ROOM.
  - WAIT_ROOM: cmd_ready=0, d_ready=0. When fifo_ready=1, go to STREAM next cycle. fifo_ready is sampled only here.
  - STREAM: cmd_ready=0, d_ready = ~m_axis_tvalid | m_axis_tready.
    - On a d_valid&d_ready beat: load the output register with d_data and tlast=(beat_cnt==len), then increment beat_cnt.
    - On the beat with tlast, go to IDLE.
    - fifo_ready dropping mid-packet has no effect.
- Output register: single stage, 1-cycle latency from d handshake to m_axis_tvalid.
  - tvalid clears on m_axis_tready when no new beat loads the same cycle.
  - A simultaneous drain and load keeps tvalid=1 with the new data, giving full throughput of 1 beat/cycle.
- AXIS rules:
  - tdata/tlast/tid/tuser hold stable while tvalid=1 and tready=0.
  - tvalid never drops without a handshake.
- tid/tuser: the output copies are updated on each load from the latched command. A new command accepted while the last beat of the previous packet still waits in the output register does not corrupt that beat.
- Back-to-back packets:
  - The cycle after the last beat loads, IDLE accepts the next command.
  - Minimum gap between packets on the source side is 2 cycles (IDLE, WAIT_ROOM).
- Lengths:
  - cmd_len=0 gives a single-beat packet with tlast on beat 0.
  - cmd_len=2^LEN_WIDTH-1 gives the maximum packet. beat_cnt is LEN_WIDTH bits wide and never wraps within a packet.
- pkt_cnt increments on m_axis_tvalid & m_axis_tready & m_axis_tlast.
- m_axis_tkeep is constant all ones.

Test Plan:
- Reset, then cmd id=0x0012 user=0x3 len=3, fifo_ready=1, d_valid continuous data 0xA0..0xA3, tready=1 -> 4 beats out on consecutive cycles starting 1 cycle after first d handshake; tid=0x0012, tuser=0x3 on all beats; tlast only on 0xA3; pkt_cnt=1.
- Same packet with tready pattern 1,0,0,1,0,1,1 -> data order preserved, outputs stable during stalls, d_ready low while register full and tready=0, no beat lost or duplicated.
- fifo_ready=0 for 10 cycles after command accept -> d_ready stays 0 and no m_axis_tvalid; fifo_ready rises -> streaming starts; dropping fifo_ready mid-packet -> packet completes.
- len=0 then len=1 back-to-back with different ids 0x1, 0x2 -> outputs are 1 beat (tlast, tid 0x1) then 2 beats (tlast on 2nd, tid 0x2); pkt_cnt=2; first beat keeps tid 0x1 even if the second command is accepted before it drains.
- Assert areset for 1 cycle after 2 of 8 beats with tready=0 -> next cycle tvalid=0, cmd_ready=1, pkt_cnt=0; a new 4-beat command completes normally.
- Random d_valid/tready for 200 packets with random len 0..15 -> scoreboard matches all data, per-packet tid/tuser, tlast positions; pkt_cnt=200.
